// File: rtl/mbist_march_ctrl_if.sv
// rtl/mbist_march_ctrl_if.sv - single-port sram access port driven by the march controller
interface mbist_march_ctrl_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] ramaddr;
  logic [DATA_W-1:0] ramin;
  logic [DATA_W-1:0] ramout;
  logic              rwbar;
  logic              cs;

  modport master (output ramaddr, ramin, rwbar, cs, input ramout);
  modport slave  (input ramaddr, ramin, rwbar, cs, output ramout);
endinterface

// File: rtl/mbist_march_ctrl.sv
// rtl/mbist_march_ctrl.sv - March C- BIST engine: one sram op per cycle, pipelined read compare
module mbist_march_ctrl #(
  parameter int                 ADDR_W       = 6,
  parameter int                 DATA_W       = 8,
  parameter logic [DATA_W-1:0]  BG_PATTERN   = 8'h00,
  parameter bit                 STOP_ON_FAIL = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  mbist_march_ctrl_if.master  ram,
  output logic                busy,
  output logic                done,
  output logic                fail,
  output logic [ADDR_W-1:0]   fail_addr,
  output logic [DATA_W-1:0]   fail_data
);
  typedef enum logic [3:0] {IDLE, M0, M1, M2, M3, M4, M5, DRAIN, DONE} state_t;

  localparam logic [DATA_W-1:0] B0    = BG_PATTERN;
  localparam logic [DATA_W-1:0] B1    = ~BG_PATTERN;
  localparam logic [ADDR_W-1:0] A_MAX = '1;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                phase_q, phase_d;
  logic                cs_d, rwbar_d, busy_d, done_d;
  logic [ADDR_W-1:0]   ramaddr_d;
  logic [DATA_W-1:0]   ramin_d;
  logic                exp_valid_q, exp_valid_d;
  logic [DATA_W-1:0]   exp_data_q, exp_data_d;
  logic [ADDR_W-1:0]   exp_addr_q;
  logic                mismatch, accept, two_op, down, in_march;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    phase_d   = phase_q;
    accept    = 1'b0;
    mismatch  = exp_valid_q && (ram.ramout != exp_data_q);
    two_op    = (state_q == M1) || (state_q == M2) || (state_q == M3) || (state_q == M4);
    down      = (state_q == M3) || (state_q == M4);

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = M0;
          addr_d  = '0;
          phase_d = 1'b0;
        end
      end
      DRAIN: state_d = DONE;
      default: begin
        if (two_op && !phase_q) begin
          phase_d = 1'b1;
        end else if (addr_q == (down ? '0 : A_MAX)) begin
          phase_d = 1'b0;
          case (state_q)
            M0:      begin state_d = M1;    addr_d = '0;    end
            M1:      begin state_d = M2;    addr_d = '0;    end
            M2:      begin state_d = M3;    addr_d = A_MAX; end
            M3:      begin state_d = M4;    addr_d = A_MAX; end
            M4:      begin state_d = M5;    addr_d = '0;    end
            default: begin state_d = DRAIN; addr_d = '0;    end
          endcase
        end else begin
          phase_d = 1'b0;
          addr_d  = down ? addr_q - 1'b1 : addr_q + 1'b1;
        end
      end
    endcase

    if (STOP_ON_FAIL && mismatch) state_d = DONE;

    // Output registers are loaded with the op that the next state will issue.
    in_march  = (state_d == M0) || (state_d == M1) || (state_d == M2) ||
                (state_d == M3) || (state_d == M4) || (state_d == M5);
    cs_d      = in_march;
    ramaddr_d = in_march ? addr_d : '0;
    rwbar_d   = 1'b1;
    ramin_d   = '0;
    case (state_d)
      M0:      begin rwbar_d = 1'b0;     ramin_d = B0; end
      M1:      begin rwbar_d = !phase_d; ramin_d = B1; end
      M2:      begin rwbar_d = !phase_d; ramin_d = B0; end
      M3:      begin rwbar_d = !phase_d; ramin_d = B1; end
      M4:      begin rwbar_d = !phase_d; ramin_d = B0; end
      M5:      begin rwbar_d = 1'b1;     ramin_d = B0; end
      default: ;
    endcase
    busy_d = in_march || (state_d == DRAIN);
    done_d = (state_d == DONE);

    exp_valid_d = ram.cs && ram.rwbar && (state_d != DONE);
    exp_data_d  = ((state_q == M2) || (state_q == M4)) ? B1 : B0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      phase_q     <= 1'b0;
      ram.cs      <= 1'b0;
      ram.rwbar   <= 1'b1;
      ram.ramaddr <= '0;
      ram.ramin   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      exp_valid_q <= 1'b0;
      exp_data_q  <= '0;
      exp_addr_q  <= '0;
      fail        <= 1'b0;
      fail_addr   <= '0;
      fail_data   <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      phase_q     <= phase_d;
      ram.cs      <= cs_d;
      ram.rwbar   <= rwbar_d;
      ram.ramaddr <= ramaddr_d;
      ram.ramin   <= ramin_d;
      busy        <= busy_d;
      done        <= done_d;
      exp_valid_q <= exp_valid_d;
      exp_data_q  <= exp_data_d;
      exp_addr_q  <= ram.ramaddr;
      // Only the first mismatch of a run is captured; a new run clears it.
      if (accept) begin
        fail      <= 1'b0;
        fail_addr <= '0;
        fail_data <= '0;
      end else if (mismatch && !fail) begin
        fail      <= 1'b1;
        fail_addr <= exp_addr_q;
        fail_data <= ram.ramout;
      end
    end
  end
endmodule

// File: tb/tb_mbist_march_ctrl.sv
// tb/tb_mbist_march_ctrl.sv - directed bench: two controllers (run-to-end and stop-on-fail) on sram models
module tb_mbist_march_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start0 = 1'b0;
  logic       start1 = 1'b0;
  logic       fault_en = 1'b0;
  logic       busy0, done0, fail0, busy1, done1, fail1;
  logic [5:0] fail_addr0, fail_addr1;
  logic [7:0] fail_data0, fail_data1;
  logic [7:0] mem0 [64];
  logic [7:0] mem1 [64];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;

  always #5 clk = ~clk;

  mbist_march_ctrl_if #(.ADDR_W(6), .DATA_W(8)) r0 ();
  mbist_march_ctrl_if #(.ADDR_W(6), .DATA_W(8)) r1 ();

  mbist_march_ctrl #(.ADDR_W(6), .DATA_W(8), .BG_PATTERN(8'h00), .STOP_ON_FAIL(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .ram(r0.master), .busy(busy0), .done(done0),
    .fail(fail0), .fail_addr(fail_addr0), .fail_data(fail_data0));

  mbist_march_ctrl #(.ADDR_W(6), .DATA_W(8), .BG_PATTERN(8'h00), .STOP_ON_FAIL(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .ram(r1.master), .busy(busy1), .done(done1),
    .fail(fail1), .fail_addr(fail_addr1), .fail_data(fail_data1));

  // sram models with an optional bit3 stuck-at-1 cell at 0x2A
  always @(posedge clk) begin
    if (r0.cs) begin
      if (r0.rwbar) r0.ramout <= mem0[r0.ramaddr];
      else mem0[r0.ramaddr] <= (fault_en && r0.ramaddr == 6'h2A) ? (r0.ramin | 8'h08) : r0.ramin;
    end
    if (r1.cs) begin
      if (r1.rwbar) r1.ramout <= mem1[r1.ramaddr];
      else mem1[r1.ramaddr] <= (fault_en && r1.ramaddr == 6'h2A) ? (r1.ramin | 8'h08) : r1.ramin;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #12;
    chk("rst_cs", r0.cs, 0);
    chk("rst_rwbar", r0.rwbar, 1);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_fail", fail0, 0);
    chk("rst_addr", r0.ramaddr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Run 1: faulty cell, both engines
    fault_en = 1'b1;
    cyc = 0;
    start0 = 1'b1; start1 = 1'b1;
    step();
    start0 = 1'b0; start1 = 1'b0;
    chk("c1_cs", r0.cs, 1);
    chk("c1_rwbar", r0.rwbar, 0);
    chk("c1_addr", r0.ramaddr, 0);
    chk("c1_ramin", r0.ramin, 8'h00);
    chk("c1_busy", busy0, 1);
    chk("c1_done", done0, 0);
    step();
    chk("c2_addr", r0.ramaddr, 1);
    chk("c2_rwbar", r0.rwbar, 0);
    run_to(65);
    chk("c65_rwbar", r0.rwbar, 1);
    chk("c65_addr", r0.ramaddr, 0);
    chk("c65_ramin", r0.ramin, 8'hFF);
    step();
    chk("c66_rwbar", r0.rwbar, 0);
    chk("c66_addr", r0.ramaddr, 0);
    run_to(150);
    chk("sof_c150_cs", r1.cs, 1);
    chk("sof_c150_done", done1, 0);
    step();
    chk("sof_done", done1, 1);
    chk("sof_cs", r1.cs, 0);
    chk("sof_busy", busy1, 0);
    chk("sof_fail", fail1, 1);
    chk("sof_fail_addr", fail_addr1, 6'h2A);
    chk("sof_fail_data", fail_data1, 8'h08);
    chk("f_fail", fail0, 1);
    chk("f_fail_addr", fail_addr0, 6'h2A);
    chk("f_fail_data", fail_data0, 8'h08);
    chk("f_busy151", busy0, 1);
    run_to(321);
    chk("m3_rwbar", r0.rwbar, 1);
    chk("m3_addr", r0.ramaddr, 6'h3F);
    chk("m3_ramin", r0.ramin, 8'hFF);
    run_to(641);
    chk("f641_cs", r0.cs, 0);
    chk("f641_busy", busy0, 1);
    chk("f641_done", done0, 0);
    step();
    chk("f642_done", done0, 1);
    chk("f642_busy", busy0, 0);
    chk("f642_fail", fail0, 1);
    chk("f642_fail_addr", fail_addr0, 6'h2A);
    chk("f642_fail_data", fail_data0, 8'h08);

    // Run 2: clean cell, restart from DONE, stray starts while busy
    fault_en = 1'b0;
    cyc = 0;
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    chk("r2_done_clr", done0, 0);
    chk("r2_fail_clr", fail0, 0);
    chk("r2_fail_addr_clr", fail_addr0, 0);
    chk("r2_busy", busy0, 1);
    run_to(9);
    start0 = 1'b1; step(); start0 = 1'b0;
    run_to(399);
    start0 = 1'b1; step(); start0 = 1'b0;
    run_to(640);
    chk("r2_c640_cs", r0.cs, 1);
    chk("r2_c640_addr", r0.ramaddr, 6'h3F);
    chk("r2_c640_rwbar", r0.rwbar, 1);
    step();
    chk("r2_c641_cs", r0.cs, 0);
    chk("r2_c641_rwbar", r0.rwbar, 1);
    chk("r2_c641_done", done0, 0);
    step();
    chk("r2_c642_done", done0, 1);
    chk("r2_c642_busy", busy0, 0);
    chk("r2_c642_fail", fail0, 0);
    chk("r2_c642_addr", r0.ramaddr, 0);
    chk("sof_idle_cs", r1.cs, 0);
    chk("sof_hold_done", done1, 1);
    step();
    chk("r2_done_held", done0, 1);

    // Run 3: async reset mid-run, then full rerun
    cyc = 0;
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    run_to(300);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_cs", r0.cs, 0);
    chk("ar_busy", busy0, 0);
    chk("ar_done", done0, 0);
    chk("ar_done1", done1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    cyc = 0;
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    chk("ar_restart_cs", r0.cs, 1);
    run_to(641);
    chk("ar_c641_done", done0, 0);
    step();
    chk("ar_c642_done", done0, 1);
    chk("ar_c642_fail", fail0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mbist_march_ctrl.md
Name: mbist_march_ctrl

Overview:
Memory BIST controller sitting directly upstream of the 64x8 single-port sram. It takes over the sram port (ramaddr, ramin, rwbar, cs) and runs a March C- algorithm on start. It compares every read against the expected background and reports pass/fail, plus the first failing address and data. This is the engine the mbist wrapper instantiates between the functional path and the sram.

Parameters:
ADDR_W, 6, sram address width; depth = 2**ADDR_W
DATA_W, 8, sram data width
BG_PATTERN, 8'h00, "zero" data background; "one" background is its bitwise inverse
STOP_ON_FAIL, 0, 1 = stop at the first mismatch, 0 = run to completion

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle pulse that launches a test; ignored while busy
ramout  input  DATA_W  sram read data, registered, valid the cycle after a read is issued
ramaddr  output  ADDR_W  sram address
ramin  output  DATA_W  sram write data
rwbar  output  1  1 = read, 0 = write
cs  output  1  sram chip select, active high
busy  output  1  test in progress
done  output  1  test finished; held until the next accepted start or reset
fail  output  1  sticky; at least one mismatch seen in the current run
fail_addr  output  ADDR_W  address of the first mismatch
fail_data  output  DATA_W  ramout value at the first mismatch

Behaviour:
- Reset (async, rst_n=0): state IDLE; cs=0, rwbar=1, ramaddr=0, ramin=0, busy=0, done=0, fail=0, fail_addr=0, fail_data=0. All outputs are registered.
- States: IDLE, M0..M5, DRAIN, DONE. B0=BG_PATTERN, B1=~BG_PATTERN.
  - M0: up, w B0.
  - M1: up, r B0 then w B1.
  - M2: up, r B1 then w B0.
  - M3: down, r B0 then w B1.
  - M4: down, r B1 then w B0.
  - M5: up, r B0.
- "Up" runs address 0..63; "down" runs 63..0. Two-op elements issue r then w to the same address on consecutive cycles, then step the address.
- Throughput: exactly one sram op per cycle while busy, with cs=1 throughout. Sequence is 640 ops (64+4*128+64).
- start in IDLE or DONE: next cycle enters M0, issues w B0 @0, busy=1, done=0, fail/fail_addr/fail_data cleared. start while busy has no effect.
- Element transition: the last op of Mk at its end address is followed next cycle by the first op of Mk+1, with no bubble.
- Compare pipeline: issuing a read registers an expected-value pointer (exp_valid, exp_data, exp_addr). In the following cycle ramout is compared with exp_data.
  - On mismatch with fail=0: set fail=1, capture fail_addr=exp_addr and fail_data=ramout.
  - Later mismatches keep fail=1 and leave the captured values unchanged.
  - A write issued in the compare cycle does not affect that compare.
- DRAIN: entered after the final M5 read (r @63). Outputs cs=0, rwbar=1. Performs the last compare, then goes to DONE.
- DONE: busy=0, done=1, cs=0, rwbar=1, ramaddr=0, ramin=0.
- STOP_ON_FAIL=1: on the first mismatch, go to DONE on the next edge, abandoning the remaining ops (cs drops to 0). fail=1.
- Idle/DONE: cs=0 so the sram is never accessed.
- Reset mid-run: immediate return to reset values. No partial results are retained.
- ramin is don't-care on reads and is driven as the write pattern of the current element.

Test Plan:
- Fault-free sram, start pulse at cycle 0 -> ops in cycles 1..640, DRAIN at 641, done=1/busy=0 from cycle 642; fail=0. First ops: w 00@0, w 00@1. Op 65 (cycle 65) is r@0 rwbar=1. M3 first op is r@63.
- Fault model: bit3 stuck-at-1 at address 0x2A -> fail=1, fail_addr=0x2A, fail_data=0x08 (first M1 read); done after 642 cycles.
- STOP_ON_FAIL=1 with the same fault -> the mismatch is compared in the cycle after r@0x2A of M1. The next edge gives done=1 and cs=0, with fail_addr=0x2A.
- Async reset: rst_n=0 at cycle 300, asserted between edges -> cs=0, busy=0, done=0 immediately. A later start reruns the full 642-cycle test.
- start pulses at cycles 10 and 400 during a run are ignored (done still at 642). start in DONE clears done/fail and restarts.
